// File: rtl/cam_capture_sequencer.sv
// Camera frame capture: syncs vsync/href/pclk into clk, pairs bytes into
// 16-bit pixels with x/y coordinates, and flags line/frame timing errors.
module cam_capture_sequencer #(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_LINES  = 480,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9
) (
  input  logic           clk,
  input  logic           res,
  input  logic           start,
  input  logic           abort,
  input  logic           vsync,
  input  logic           href,
  input  logic           pclk,
  input  logic [7:0]     cam_data,
  output logic           pix_valid,
  output logic [15:0]    pix_data,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           frame_start,
  output logic           frame_done,
  output logic           busy,
  output logic           err_line,
  output logic           err_frame
);

  localparam int unsigned BC_W = X_W + 1;
  localparam int unsigned LC_W = Y_W + 1;
  localparam logic [BC_W-1:0] BYTES_C = BC_W'(2 * H_PIXELS);
  localparam logic [LC_W-1:0] LINES_C = LC_W'(V_LINES);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_VS_HI, S_WAIT_VS_LO, S_ACTIVE, S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [1:0] r_vs_s, r_hr_s, r_pc_s;
  logic       r_vs_d, r_hr_d, r_pc_d;
  logic       r_vs_rise, r_vs_fall, r_hr_rise, r_hr_fall, r_pc_rise;

  logic [BC_W-1:0] r_byte;
  logic [LC_W-1:0] r_line;
  logic [7:0]      r_hi;
  logic            r_pix_valid, r_frame_start, r_frame_done, r_busy;
  logic            r_err_line, r_err_frame;
  logic [15:0]     r_pix_data;
  logic [X_W-1:0]  r_pix_x;
  logic [Y_W-1:0]  r_pix_y;

  logic w_line_last, w_early_vs, w_abort;

  // Edge pulses are registered so they stay aligned with the delayed levels
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_vs_s    <= '0;
      r_hr_s    <= '0;
      r_pc_s    <= '0;
      r_vs_d    <= 1'b0;
      r_hr_d    <= 1'b0;
      r_pc_d    <= 1'b0;
      r_vs_rise <= 1'b0;
      r_vs_fall <= 1'b0;
      r_hr_rise <= 1'b0;
      r_hr_fall <= 1'b0;
      r_pc_rise <= 1'b0;
    end else begin
      r_vs_s    <= {r_vs_s[0], vsync};
      r_hr_s    <= {r_hr_s[0], href};
      r_pc_s    <= {r_pc_s[0], pclk};
      r_vs_d    <= r_vs_s[1];
      r_hr_d    <= r_hr_s[1];
      r_pc_d    <= r_pc_s[1];
      r_vs_rise <= r_vs_s[1] & ~r_vs_d;
      r_vs_fall <= ~r_vs_s[1] & r_vs_d;
      r_hr_rise <= r_hr_s[1] & ~r_hr_d;
      r_hr_fall <= ~r_hr_s[1] & r_hr_d;
      r_pc_rise <= r_pc_s[1] & ~r_pc_d;
    end
  end

  assign w_abort     = abort && (r_state != S_IDLE);
  assign w_line_last = r_hr_fall && ((r_line + LC_W'(1)) == LINES_C);
  assign w_early_vs  = r_vs_rise && (r_line < LINES_C);

  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:       if (start) w_state_nxt = S_WAIT_VS_HI;
        S_WAIT_VS_HI: if (r_vs_d) w_state_nxt = S_WAIT_VS_LO;
        S_WAIT_VS_LO: if (r_vs_fall) w_state_nxt = S_ACTIVE;
        S_ACTIVE:     if (w_line_last || w_early_vs) w_state_nxt = S_DONE;
        S_DONE:       w_state_nxt = S_IDLE;
        default:      w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Counters, pixel pairing and flags; nothing is emitted in an abort cycle
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_byte        <= '0;
      r_line        <= '0;
      r_hi          <= '0;
      r_pix_valid   <= 1'b0;
      r_pix_data    <= '0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
      r_err_line    <= 1'b0;
      r_err_frame   <= 1'b0;
    end else begin
      r_pix_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy      <= 1'b1;
            r_err_line  <= 1'b0;
            r_err_frame <= 1'b0;
          end
        end
        S_WAIT_VS_LO: begin
          if (!abort && r_vs_fall) begin
            r_line <= '0;
            r_byte <= '0;
          end
        end
        S_ACTIVE: begin
          if (!abort) begin
            if (r_hr_rise) begin
              r_byte <= '0;
              if (r_line == '0) r_frame_start <= 1'b1;
            end else if (r_pc_rise && r_hr_d) begin
              if (r_byte < BYTES_C) begin
                if (!r_byte[0]) begin
                  r_hi <= cam_data;
                end else begin
                  r_pix_valid <= 1'b1;
                  r_pix_data  <= {r_hi, cam_data};
                  r_pix_x     <= X_W'(r_byte >> 1);
                  r_pix_y     <= Y_W'(r_line);
                end
                r_byte <= r_byte + BC_W'(1);
              end else begin
                r_err_line <= 1'b1;
              end
            end
            if (r_hr_fall) begin
              if (r_byte != BYTES_C) r_err_line <= 1'b1;
              r_line <= r_line + LC_W'(1);
            end
            if (w_early_vs) r_err_frame <= 1'b1;
          end
        end
        S_DONE: begin
          r_frame_done <= 1'b1;
          r_busy       <= 1'b0;
        end
        default: ;
      endcase
      if (w_abort) r_busy <= 1'b0;
    end
  end

  assign pix_valid   = r_pix_valid;
  assign pix_data    = r_pix_data;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign busy        = r_busy;
  assign err_line    = r_err_line;
  assign err_frame   = r_err_frame;

endmodule

// File: tb/tb_cam_capture_sequencer.sv
// Bench for cam_capture_sequencer: drives a small camera frame model and
// checks captured pixels against a queue built from the bytes sent.
module tb_cam_capture_sequencer;

  localparam int unsigned H  = 8;
  localparam int unsigned V  = 6;
  localparam int unsigned XW = 4;
  localparam int unsigned YW = 3;

  logic          clk = 1'b0;
  logic          res, start, abort, vsync, href, pclk;
  logic [7:0]    cam_data;
  logic          pix_valid, frame_start, frame_done, busy, err_line, err_frame;
  logic [15:0]   pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;

  typedef struct {
    logic [15:0] d;
    int          x;
    int          y;
  } pix_t;

  pix_t exp_q[$];
  pix_t obs_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_fs     = 0;
  int   n_fd     = 0;
  logic busy_at_done = 1'b1;

  cam_capture_sequencer #(.H_PIXELS(H), .V_LINES(V), .X_W(XW), .Y_W(YW)) dut (
    .clk(clk), .res(res), .start(start), .abort(abort), .vsync(vsync),
    .href(href), .pclk(pclk), .cam_data(cam_data), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
    .err_line(err_line), .err_frame(err_frame)
  );

  always #1 clk = ~clk;

  always @(negedge clk) begin
    if (pix_valid) obs_q.push_back('{pix_data, int'(pix_x), int'(pix_y)});
    if (frame_start) n_fs++;
    if (frame_done) begin
      n_fd++;
      busy_at_done = busy;
    end
  end

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_vsync;
    vsync = 1'b1; #80;
    vsync = 1'b0; #80;
  endtask

  // One camera line; the model keeps only complete pairs within the first 2*H bytes
  task automatic send_line(input int y, input int nbytes, input bit ramp, input bit rec);
    logic [7:0] b[$];
    logic [7:0] v;
    for (int i = 0; i < nbytes; i++) begin
      v = ramp ? 8'(i) : 8'($urandom);
      b.push_back(v);
      pclk = 1'b0; cam_data = v; href = 1'b1; #16;
      pclk = 1'b1; #16;
    end
    pclk = 1'b0; href = 1'b0;
    #(32 + 2 * $urandom_range(0, 16));
    if (rec)
      for (int k = 0; (2*k+1 < nbytes) && (2*k+1 < 2*H); k++)
        exp_q.push_back('{{b[2*k], b[2*k+1]}, k, y});
  endtask

  task automatic send_frame(input int nl, input bit ramp, input bit rec,
                            input int odd_line, input int odd_len);
    send_vsync();
    for (int y = 0; y < nl; y++)
      send_line(y, (y == odd_line) ? odd_len : 2*H, ramp, rec);
  endtask

  task automatic wait_done(input int fd0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (n_fd > fd0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset;
    res = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pix_valid !== 1'b0 || pix_data !== 16'h0 || pix_x !== '0 || pix_y !== '0) begin
      n_fail++;
      $display("FAIL reset_pix: valid=%b data=%h x=%0d y=%0d want 0", pix_valid, pix_data, pix_x, pix_y);
    end
    n_checks++;
    if (busy !== 1'b0 || frame_start !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b fs=%b fd=%b want 0", busy, frame_start, frame_done);
    end
    n_checks++;
    if (err_line !== 1'b0 || err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: err_line=%b err_frame=%b want 0", err_line, err_frame);
    end
    res = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_nominal;
    int base, fs0, fd0;
    bit ok;
    base = obs_q.size(); fs0 = n_fs; fd0 = n_fd;
    exp_q.delete();
    pulse_start();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal_busy_hi: got %b want 1", busy);
    end
    send_frame(V, 1'b1, 1'b1, -1, 0);
    wait_done(fd0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL nominal_done_timeout: got 0 want 1"); end
    n_checks++;
    if (obs_q.size() - base != H*V) begin
      n_fail++;
      $display("FAIL nominal_count: got %0d want %0d", obs_q.size() - base, H*V);
    end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[base+i].d !== exp_q[i].d || obs_q[base+i].x != exp_q[i].x || obs_q[base+i].y != exp_q[i].y) begin
        n_fail++;
        $display("FAIL nominal_pix[%0d]: got %h/%0d/%0d want %h/%0d/%0d", i, obs_q[base+i].d,
                 obs_q[base+i].x, obs_q[base+i].y, exp_q[i].d, exp_q[i].x, exp_q[i].y);
      end
    end
    if (obs_q.size() >= base + 2) begin
      n_checks++;
      if (obs_q[base].d !== 16'h0001 || obs_q[base].x != 0 || obs_q[base].y != 0) begin
        n_fail++;
        $display("FAIL nominal_first: got %h/%0d/%0d want 0001/0/0", obs_q[base].d, obs_q[base].x, obs_q[base].y);
      end
      n_checks++;
      if (obs_q[base+1].d !== 16'h0203 || obs_q[base+1].x != 1) begin
        n_fail++;
        $display("FAIL nominal_second: got %h/%0d want 0203/1", obs_q[base+1].d, obs_q[base+1].x);
      end
      n_checks++;
      if (obs_q[obs_q.size()-1].x != H-1 || obs_q[obs_q.size()-1].y != V-1) begin
        n_fail++;
        $display("FAIL nominal_last: got %0d/%0d want %0d/%0d", obs_q[obs_q.size()-1].x,
                 obs_q[obs_q.size()-1].y, H-1, V-1);
      end
    end
    n_checks++;
    if (n_fs - fs0 != 1 || n_fd - fd0 != 1) begin
      n_fail++;
      $display("FAIL nominal_pulses: got fs=%0d fd=%0d want 1/1", n_fs - fs0, n_fd - fd0);
    end
    n_checks++;
    if (busy_at_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_busy_fall: got at_done=%b now=%b want 0/0", busy_at_done, busy);
    end
    n_checks++;
    if (err_line !== 1'b0 || err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_err: got %b/%b want 0/0", err_line, err_frame);
    end
  endtask

  task automatic test_midframe_start;
    int base, fd0;
    bit ok;
    base = obs_q.size(); fd0 = n_fd;
    exp_q.delete();
    send_vsync();
    for (int y = 0; y < 2; y++) send_line(y, 2*H, 1'b0, 1'b0);
    fork
      send_line(2, 2*H, 1'b0, 1'b0);
      begin #100; pulse_start(); end
    join
    for (int y = 3; y < V; y++) send_line(y, 2*H, 1'b0, 1'b0);
    n_checks++;
    if (obs_q.size() != base) begin
      n_fail++;
      $display("FAIL midframe_partial: got %0d strobes want 0", obs_q.size() - base);
    end
    send_frame(V, 1'b0, 1'b1, -1, 0);
    wait_done(fd0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midframe_done_timeout: got 0 want 1"); end
    n_checks++;
    if (obs_q.size() - base != exp_q.size()) begin
      n_fail++;
      $display("FAIL midframe_count: got %0d want %0d", obs_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[base+i].d !== exp_q[i].d || obs_q[base+i].x != exp_q[i].x || obs_q[base+i].y != exp_q[i].y) begin
        n_fail++;
        $display("FAIL midframe_pix[%0d]: got %h/%0d/%0d want %h/%0d/%0d", i, obs_q[base+i].d,
                 obs_q[base+i].x, obs_q[base+i].y, exp_q[i].d, exp_q[i].x, exp_q[i].y);
      end
    end
  endtask

  // Shared scenario for short/long lines: one odd-length line in an otherwise full frame
  task automatic test_odd_line(input int odd_y, input int odd_len, input int want_on_line);
    int base, fd0, on_line;
    bit ok;
    base = obs_q.size(); fd0 = n_fd; on_line = 0;
    exp_q.delete();
    pulse_start();
    send_frame(V, 1'b0, 1'b1, odd_y, odd_len);
    wait_done(fd0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL oddline_done_timeout len=%0d: got 0 want 1", odd_len); end
    n_checks++;
    if (err_line !== 1'b1 || err_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL oddline_err len=%0d: got %b/%b want 1/0", odd_len, err_line, err_frame);
    end
    for (int i = base; i < obs_q.size(); i++) if (obs_q[i].y == odd_y) on_line++;
    n_checks++;
    if (on_line != want_on_line) begin
      n_fail++;
      $display("FAIL oddline_strobes len=%0d: got %0d want %0d", odd_len, on_line, want_on_line);
    end
    n_checks++;
    if (obs_q.size() - base != exp_q.size()) begin
      n_fail++;
      $display("FAIL oddline_count len=%0d: got %0d want %0d", odd_len, obs_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[base+i].d !== exp_q[i].d || obs_q[base+i].x != exp_q[i].x || obs_q[base+i].y != exp_q[i].y) begin
        n_fail++;
        $display("FAIL oddline_pix[%0d]: got %h/%0d/%0d want %h/%0d/%0d", i, obs_q[base+i].d,
                 obs_q[base+i].x, obs_q[base+i].y, exp_q[i].d, exp_q[i].x, exp_q[i].y);
      end
    end
  endtask

  task automatic test_short_line;
    test_odd_line(2, 2*H - 2, H - 1);
  endtask

  task automatic test_long_line;
    test_odd_line(3, 2*H + 2, H);
  endtask

  task automatic test_early_vsync;
    int base, fd0;
    bit ok;
    base = obs_q.size(); fd0 = n_fd;
    exp_q.delete();
    pulse_start();
    send_frame(3, 1'b0, 1'b1, -1, 0);
    send_vsync();
    wait_done(fd0, ok);
    n_checks++;
    if (!ok || n_fd - fd0 != 1) begin
      n_fail++;
      $display("FAIL early_done: got %0d pulses want 1", n_fd - fd0);
    end
    n_checks++;
    if (err_frame !== 1'b1 || err_line !== 1'b0) begin
      n_fail++;
      $display("FAIL early_err: got frame=%b line=%b want 1/0", err_frame, err_line);
    end
    n_checks++;
    if (obs_q.size() - base != 3*H || obs_q.size() == 0 || obs_q[obs_q.size()-1].y != 2) begin
      n_fail++;
      $display("FAIL early_last_y: got count %0d want %0d, last y 2", obs_q.size() - base, 3*H);
    end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[base+i].d !== exp_q[i].d || obs_q[base+i].x != exp_q[i].x || obs_q[base+i].y != exp_q[i].y) begin
        n_fail++;
        $display("FAIL early_pix[%0d]: got %h/%0d/%0d want %h/%0d/%0d", i, obs_q[base+i].d,
                 obs_q[base+i].x, obs_q[base+i].y, exp_q[i].d, exp_q[i].x, exp_q[i].y);
      end
    end
  endtask

  task automatic test_abort;
    int base, fd0, snap;
    bit ok;
    fd0 = n_fd; snap = 0;
    pulse_start();
    send_vsync();
    for (int y = 0; y < 2; y++) send_line(y, 2*H, 1'b0, 1'b0);
    fork
      send_line(2, 2*H, 1'b0, 1'b0);
      begin
        #200;
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_busy: got %b want 0", busy);
        end
        snap = obs_q.size();
      end
    join
    for (int y = 3; y < V; y++) send_line(y, 2*H, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    n_checks++;
    if (obs_q.size() != snap || n_fd != fd0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d strobes %0d done want 0/0", obs_q.size() - snap, n_fd - fd0);
    end
    base = obs_q.size();
    exp_q.delete();
    pulse_start();
    send_frame(V, 1'b0, 1'b1, -1, 0);
    wait_done(fd0, ok);
    n_checks++;
    if (!ok || obs_q.size() - base != H*V) begin
      n_fail++;
      $display("FAIL abort_recapture: got done=%b count=%0d want 1/%0d", ok, obs_q.size() - base, H*V);
    end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[base+i].d !== exp_q[i].d || obs_q[base+i].x != exp_q[i].x || obs_q[base+i].y != exp_q[i].y) begin
        n_fail++;
        $display("FAIL abort_pix[%0d]: got %h/%0d/%0d want %h/%0d/%0d", i, obs_q[base+i].d,
                 obs_q[base+i].x, obs_q[base+i].y, exp_q[i].d, exp_q[i].x, exp_q[i].y);
      end
    end
  endtask

  task automatic test_reset_midline;
    pulse_start();
    send_vsync();
    fork
      send_line(0, 2*H, 1'b0, 1'b0);
      begin
        #150;
        res = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || pix_valid !== 1'b0 || pix_data !== 16'h0 || pix_x !== '0 || pix_y !== '0) begin
          n_fail++;
          $display("FAIL midreset_pix: busy=%b valid=%b data=%h x=%0d y=%0d want 0", busy, pix_valid,
                   pix_data, pix_x, pix_y);
        end
        n_checks++;
        if (frame_start !== 1'b0 || frame_done !== 1'b0 || err_line !== 1'b0 || err_frame !== 1'b0) begin
          n_fail++;
          $display("FAIL midreset_flags: fs=%b fd=%b el=%b ef=%b want 0", frame_start, frame_done,
                   err_line, err_frame);
        end
        #20;
        @(negedge clk) res = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_after: busy got %b want 0", busy);
    end
  endtask

  initial begin
    res = 1'b1; start = 1'b0; abort = 1'b0;
    vsync = 1'b0; href = 1'b0; pclk = 1'b0; cam_data = 8'h00;
    test_reset();
    test_nominal();
    test_midframe_start();
    test_short_line();
    test_long_line();
    test_early_vsync();
    test_abort();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
